// File: rtl/countdown_ctrl_if.sv
// Key, tick and datapath signals of the countdown controller.
// master: the controller side; slave: the key block / datapath side.
interface countdown_ctrl_if;
  logic       TICK;
  logic       ZERO;
  logic       KEY_SET;
  logic       KEY_INC;
  logic       KEY_START;
  logic       KEY_STOP;
  logic [7:0] D_H;
  logic [7:0] D_M;
  logic [7:0] D_S;
  logic       PE;
  logic       CE;
  logic       CLR;
  logic       RING;
  logic [1:0] FIELD;

  modport master (
    input  TICK, ZERO, KEY_SET, KEY_INC, KEY_START, KEY_STOP,
    output D_H, D_M, D_S, PE, CE, CLR, RING, FIELD
  );

  modport slave (
    output TICK, ZERO, KEY_SET, KEY_INC, KEY_START, KEY_STOP,
    input  D_H, D_M, D_S, PE, CE, CLR, RING, FIELD
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Moore controller for the BCD HH:MM:SS countdown timer: preset editing,
// datapath load/enable/clear sequencing and a self-stopping expiry alarm.
module countdown_ctrl #(
  parameter int unsigned RING_TICKS = 60,
  parameter logic [7:0]  H_MAX      = 8'h23,
  parameter logic [7:0]  M_MAX      = 8'h59,
  parameter logic [7:0]  S_MAX      = 8'h59
) (
  input  logic              CP,
  input  logic              CR,
  countdown_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SET_H = 4'd1,
    ST_SET_M = 4'd2,
    ST_SET_S = 4'd3,
    ST_LOAD  = 4'd4,
    ST_RUN   = 4'd5,
    ST_PAUSE = 4'd6,
    ST_ALARM = 4'd7,
    ST_ABORT = 4'd8
  } state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_TICKS - 1);

  state_t     state_q, state_d;
  logic [7:0] d_h_q, d_h_d;
  logic [7:0] d_m_q, d_m_d;
  logic [7:0] d_s_q, d_s_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;

  // Keys after priority arbitration: at most one of these is high.
  logic key_stop, key_start, key_set, key_inc;
  logic preset_zero;

  // BCD increment with wrap from the field maximum back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)
      return 8'h00;
    else if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'h1};
  endfunction

  // Key arbitration STOP > START > SET > INC and preset-empty detect.
  always_comb begin
    key_stop    = bus.KEY_STOP;
    key_start   = bus.KEY_START & ~bus.KEY_STOP;
    key_set     = bus.KEY_SET & ~bus.KEY_START & ~bus.KEY_STOP;
    key_inc     = bus.KEY_INC & ~bus.KEY_SET & ~bus.KEY_START & ~bus.KEY_STOP;
    preset_zero = ((d_h_q | d_m_q | d_s_q) == 8'h00);
  end

  // State, preset and ring-counter registers.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q    <= ST_IDLE;
      d_h_q      <= 8'h00;
      d_m_q      <= 8'h00;
      d_s_q      <= 8'h00;
      ring_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      d_h_q      <= d_h_d;
      d_m_q      <= d_m_d;
      d_s_q      <= d_s_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  // Next-state, preset editing and alarm duration counting.
  always_comb begin
    state_d    = state_q;
    d_h_d      = d_h_q;
    d_m_d      = d_m_q;
    d_s_d      = d_s_q;
    ring_cnt_d = ring_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_set)
          state_d = ST_SET_H;
        else if (key_start && !preset_zero)
          state_d = ST_LOAD;
      end
      ST_SET_H: begin
        if (key_stop)     state_d = ST_IDLE;
        else if (key_set) state_d = ST_SET_M;
        else if (key_inc) d_h_d   = bcd_inc(d_h_q, H_MAX);
      end
      ST_SET_M: begin
        if (key_stop)     state_d = ST_IDLE;
        else if (key_set) state_d = ST_SET_S;
        else if (key_inc) d_m_d   = bcd_inc(d_m_q, M_MAX);
      end
      ST_SET_S: begin
        if (key_stop)     state_d = ST_IDLE;
        else if (key_set) state_d = ST_IDLE;
        else if (key_inc) d_s_d   = bcd_inc(d_s_q, S_MAX);
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (key_stop) begin
          state_d = ST_ABORT;
        end else if (bus.ZERO) begin
          state_d    = ST_ALARM;
          ring_cnt_d = 8'h00;
        end else if (key_start) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (key_stop)       state_d = ST_ABORT;
        else if (key_start) state_d = ST_RUN;
      end
      ST_ALARM: begin
        if (key_stop || key_start) begin
          state_d = ST_IDLE;
        end else if (bus.TICK) begin
          if (ring_cnt_q == RING_LAST)
            state_d = ST_IDLE;
          else
            ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded purely from the registered state and preset.
  always_comb begin
    bus.D_H   = d_h_q;
    bus.D_M   = d_m_q;
    bus.D_S   = d_s_q;
    bus.PE    = (state_q == ST_LOAD);
    bus.CE    = (state_q == ST_RUN);
    bus.CLR   = (state_q == ST_ABORT);
    bus.RING  = (state_q == ST_ALARM);
    bus.FIELD = 2'd0;
    if (state_q == ST_SET_H) bus.FIELD = 2'd1;
    if (state_q == ST_SET_M) bus.FIELD = 2'd2;
    if (state_q == ST_SET_S) bus.FIELD = 2'd3;
  end

endmodule
